// File: rtl/lfsr_prog.sv
// Runtime-programmable Fibonacci LFSR with handshake-loaded taps/seed,
// zero-state lock-up recovery and a period-measurement engine.
module lfsr_prog #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] DEFAULT_TAPS = (WIDTH'(1) << (WIDTH-1)) | WIDTH'(1),
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1),
    parameter int               CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [WIDTH-1:0] i_cfg_taps,
    input  logic [WIDTH-1:0] i_cfg_seed,
    input  logic             i_meas_start,
    output logic [WIDTH-1:0] o_lfsr,
    output logic             o_bit_out,
    output logic             o_lockup,
    output logic [CNT_W-1:0] o_period,
    output logic             o_period_valid
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_taps;
    logic [WIDTH-1:0] r_seed;
    logic [WIDTH-1:0] r_ref;
    logic [WIDTH-1:0] w_ref_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] w_period_nxt;
    logic             r_period_valid;
    logic             w_period_valid_nxt;
    logic             r_lockup;

    logic             w_cfg_ready;
    logic             w_cfg_xfer;
    logic [WIDTH-1:0] w_cfg_seed;
    logic             w_fb;
    logic [WIDTH-1:0] w_shift;
    logic             w_recover;

    assign w_cfg_ready = (r_state == ST_RUN);
    assign w_cfg_xfer  = i_cfg_valid & w_cfg_ready;
    // A zero seed would lock the register up immediately, so substitute the default.
    assign w_cfg_seed  = (i_cfg_seed == '0) ? DEFAULT_SEED : i_cfg_seed;

    assign w_fb      = ^(r_lfsr & r_taps);
    assign w_shift   = {r_lfsr[WIDTH-2:0], w_fb};
    assign w_recover = ~w_cfg_xfer & i_en & (r_lfsr == '0);
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lfsr   <= DEFAULT_SEED;
            r_taps   <= DEFAULT_TAPS;
            r_seed   <= DEFAULT_SEED;
            r_lockup <= 1'b0;
        end else begin
            r_lockup <= w_recover;
            if (w_cfg_xfer) begin
                r_taps <= i_cfg_taps;
                r_seed <= w_cfg_seed;
                r_lfsr <= w_cfg_seed;
            end else if (w_recover) begin
                r_lfsr <= r_seed;
            end else if (i_en) begin
                r_lfsr <= w_shift;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_RUN;
            r_ref          <= '0;
            r_cnt          <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_ref          <= w_ref_nxt;
            r_cnt          <= w_cnt_nxt;
            r_period       <= w_period_nxt;
            r_period_valid <= w_period_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_ref_nxt          = r_ref;
        w_cnt_nxt          = r_cnt;
        w_period_nxt       = r_period;
        w_period_valid_nxt = r_period_valid;

        if (w_cfg_xfer) begin
            w_period_valid_nxt = 1'b0;
        end

        case (r_state)
            ST_RUN: begin
                if (i_meas_start && !w_cfg_xfer) begin
                    w_ref_nxt          = r_lfsr;
                    w_cnt_nxt          = '0;
                    w_period_valid_nxt = 1'b0;
                    w_state_nxt        = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                // Match is tested on the shifted value, so a recovery reload of the
                // reference seed reports a lock-up rather than a bogus period.
                if (i_en) begin
                    if (w_shift == r_ref) begin
                        w_period_nxt       = w_cnt_inc;
                        w_period_valid_nxt = 1'b1;
                        w_state_nxt        = ST_RUN;
                    end else if (&w_cnt_inc) begin
                        w_period_nxt       = '1;
                        w_period_valid_nxt = 1'b1;
                        w_state_nxt        = ST_RUN;
                    end else if (w_recover) begin
                        w_period_nxt       = '0;
                        w_period_valid_nxt = 1'b1;
                        w_state_nxt        = ST_RUN;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign o_cfg_ready    = w_cfg_ready;
    assign o_lfsr         = r_lfsr;
    assign o_bit_out      = r_lfsr[WIDTH-1];
    assign o_lockup       = r_lockup;
    assign o_period       = r_period;
    assign o_period_valid = r_period_valid;

endmodule

// File: tb/tb_lfsr_prog.sv
// Directed bench for lfsr_prog at WIDTH=4, CNT_W=8 with hand-computed sequences.
module tb_lfsr_prog;

    logic       i_clk;
    logic       i_reset;
    logic       i_en;
    logic       i_cfg_valid;
    logic       o_cfg_ready;
    logic [3:0] i_cfg_taps;
    logic [3:0] i_cfg_seed;
    logic       i_meas_start;
    logic [3:0] o_lfsr;
    logic       o_bit_out;
    logic       o_lockup;
    logic [7:0] o_period;
    logic       o_period_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // x^4+x+1 sequence from 1010 with taps 1001
    logic [3:0] seq15 [15] = '{4'b1010, 4'b0101, 4'b1011, 4'b0110, 4'b1100,
                               4'b1001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                               4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101};

    lfsr_prog #(
        .WIDTH       (4),
        .DEFAULT_TAPS(4'b1001),
        .DEFAULT_SEED(4'b0001),
        .CNT_W       (8)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_en          (i_en),
        .i_cfg_valid   (i_cfg_valid),
        .o_cfg_ready   (o_cfg_ready),
        .i_cfg_taps    (i_cfg_taps),
        .i_cfg_seed    (i_cfg_seed),
        .i_meas_start  (i_meas_start),
        .o_lfsr        (o_lfsr),
        .o_bit_out     (o_bit_out),
        .o_lockup      (o_lockup),
        .o_period      (o_period),
        .o_period_valid(o_period_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_cfg(input logic [3:0] taps, input logic [3:0] seed);
        i_cfg_valid = 1'b1;
        i_cfg_taps  = taps;
        i_cfg_seed  = seed;
        tick();
        i_cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (o_lfsr !== 4'b0001) begin n_fail++; $display("FAIL reset_lfsr: got %b want 0001", o_lfsr); end
        n_checks++;
        if (o_period_valid !== 1'b0 || o_period !== 8'h00) begin
            n_fail++; $display("FAIL reset_period: got pv=%b p=%h want pv=0 p=00", o_period_valid, o_period);
        end
        n_checks++;
        if (o_cfg_ready !== 1'b1 || o_lockup !== 1'b0 || o_bit_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got rdy=%b lk=%b bo=%b want 1 0 0", o_cfg_ready, o_lockup, o_bit_out);
        end
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        tick();
        // default taps 1001 from 0001 with en low: must hold
        n_checks++;
        if (o_lfsr !== 4'b0001) begin n_fail++; $display("FAIL reset_hold: got %b want 0001", o_lfsr); end
    endtask

    task automatic test_sequence();
        i_en = 1'b1;
        do_cfg(4'b1001, 4'b1010);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (o_lfsr !== seq15[i] || o_bit_out !== seq15[i][3]) begin
                n_fail++; $display("FAIL seq_step%0d: got %b/%b want %b", i, o_lfsr, o_bit_out, seq15[i]);
            end
            if (i < 3) tick();
        end
        i_en = 1'b0;
    endtask

    task automatic test_period15();
        i_meas_start = 1'b1;
        tick();
        i_meas_start = 1'b0;
        n_checks++;
        if (o_cfg_ready !== 1'b0 || o_period_valid !== 1'b0) begin
            n_fail++; $display("FAIL p15_enter: got rdy=%b pv=%b want 0 0", o_cfg_ready, o_period_valid);
        end
        i_en = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        n_checks++;
        if (o_period_valid !== 1'b0) begin n_fail++; $display("FAIL p15_early: got pv=%b want 0", o_period_valid); end
        tick();
        i_en = 1'b0;
        n_checks++;
        if (o_period_valid !== 1'b1 || o_period !== 8'd15 || o_lfsr !== 4'b0110 || o_cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL p15_done: got pv=%b p=%0d lfsr=%b rdy=%b want 1 15 0110 1",
                               o_period_valid, o_period, o_lfsr, o_cfg_ready);
        end
    endtask

    task automatic test_pause_and_blocked_cfg();
        i_meas_start = 1'b1;
        tick();
        i_meas_start = 1'b0;
        i_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        i_en = 1'b0;
        tick();
        i_meas_start = 1'b1;
        tick();
        i_meas_start = 1'b0;
        i_cfg_valid = 1'b1;
        i_cfg_taps  = 4'b0000;
        i_cfg_seed  = 4'b1111;
        n_checks++;
        if (o_cfg_ready !== 1'b0) begin n_fail++; $display("FAIL meas_ready: got %b want 0", o_cfg_ready); end
        tick();
        i_cfg_valid = 1'b0;
        n_checks++;
        if (o_lfsr !== 4'b1000) begin n_fail++; $display("FAIL pause_hold: got %b want 1000", o_lfsr); end
        i_en = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        n_checks++;
        if (o_period_valid !== 1'b0) begin n_fail++; $display("FAIL pause_early: got pv=%b want 0", o_period_valid); end
        tick();
        i_en = 1'b0;
        n_checks++;
        if (o_period_valid !== 1'b1 || o_period !== 8'd15 || o_lfsr !== 4'b0110) begin
            n_fail++; $display("FAIL pause_done: got pv=%b p=%0d lfsr=%b want 1 15 0110",
                               o_period_valid, o_period, o_lfsr);
        end
    endtask

    task automatic test_lockup();
        logic [3:0] exp_l [5] = '{4'b0100, 4'b1000, 4'b0000, 4'b1010, 4'b0100};
        logic       exp_k [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_cfg(4'b0000, 4'b1010);
        n_checks++;
        if (o_lfsr !== 4'b1010 || o_period_valid !== 1'b0) begin
            n_fail++; $display("FAIL lk_cfg: got lfsr=%b pv=%b want 1010 0", o_lfsr, o_period_valid);
        end
        i_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (o_lfsr !== exp_l[i] || o_lockup !== exp_k[i]) begin
                n_fail++; $display("FAIL lk_step%0d: got %b lk=%b want %b lk=%b", i, o_lfsr, o_lockup, exp_l[i], exp_k[i]);
            end
        end
        i_en = 1'b0;
    endtask

    task automatic test_lockup_measure();
        do_cfg(4'b0000, 4'b1010);
        i_meas_start = 1'b1;
        tick();
        i_meas_start = 1'b0;
        i_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (o_period_valid !== 1'b0 || o_lfsr !== 4'b0000) begin
            n_fail++; $display("FAIL lkm_pre: got pv=%b lfsr=%b want 0 0000", o_period_valid, o_lfsr);
        end
        tick();
        i_en = 1'b0;
        n_checks++;
        if (o_period_valid !== 1'b1 || o_period !== 8'd0 || o_lockup !== 1'b1 || o_lfsr !== 4'b1010) begin
            n_fail++; $display("FAIL lkm_done: got pv=%b p=%0d lk=%b lfsr=%b want 1 0 1 1010",
                               o_period_valid, o_period, o_lockup, o_lfsr);
        end
    endtask

    task automatic test_saturate();
        int seen = 0;
        do_cfg(4'b0011, 4'b1010);
        i_meas_start = 1'b1;
        tick();
        i_meas_start = 1'b0;
        i_en = 1'b1;
        for (int i = 0; i < 254; i++) begin
            tick();
            if (o_lfsr === 4'b1010) seen++;
        end
        n_checks++;
        if (o_period_valid !== 1'b0 || seen != 0) begin
            n_fail++; $display("FAIL sat_early: got pv=%b recurrences=%0d want 0 0", o_period_valid, seen);
        end
        tick();
        i_en = 1'b0;
        n_checks++;
        if (o_period_valid !== 1'b1 || o_period !== 8'hFF || o_lfsr !== 4'b0110) begin
            n_fail++; $display("FAIL sat_done: got pv=%b p=%h lfsr=%b want 1 ff 0110",
                               o_period_valid, o_period, o_lfsr);
        end
    endtask

    task automatic test_zero_seed_with_meas();
        i_meas_start = 1'b1;
        do_cfg(4'b0000, 4'b0000);
        i_meas_start = 1'b0;
        n_checks++;
        if (o_lfsr !== 4'b0001 || o_cfg_ready !== 1'b1 || o_period_valid !== 1'b0) begin
            n_fail++; $display("FAIL zs_cfg: got lfsr=%b rdy=%b pv=%b want 0001 1 0", o_lfsr, o_cfg_ready, o_period_valid);
        end
        i_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        i_en = 1'b0;
        n_checks++;
        if (o_lfsr !== 4'b0001 || o_lockup !== 1'b1 || o_cfg_ready !== 1'b1 || o_period !== 8'hFF) begin
            n_fail++; $display("FAIL zs_recover: got lfsr=%b lk=%b rdy=%b p=%h want 0001 1 1 ff",
                               o_lfsr, o_lockup, o_cfg_ready, o_period);
        end
    endtask

    task automatic test_reset_mid_measure();
        do_cfg(4'b1001, 4'b1010);
        i_meas_start = 1'b1;
        tick();
        i_meas_start = 1'b0;
        i_en = 1'b1;
        tick();
        tick();
        #2;
        i_reset = 1'b1;
        #1;
        n_checks++;
        if (o_lfsr !== 4'b0001 || o_period_valid !== 1'b0 || o_cfg_ready !== 1'b1 || o_period !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid: got lfsr=%b pv=%b rdy=%b p=%h want 0001 0 1 00",
                               o_lfsr, o_period_valid, o_cfg_ready, o_period);
        end
        i_en = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        tick();
        n_checks++;
        if (o_lfsr !== 4'b0001 || o_cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_after: got lfsr=%b rdy=%b want 0001 1", o_lfsr, o_cfg_ready);
        end
    endtask

    initial begin
        i_reset      = 1'b1;
        i_en         = 1'b0;
        i_cfg_valid  = 1'b0;
        i_cfg_taps   = 4'b0000;
        i_cfg_seed   = 4'b0000;
        i_meas_start = 1'b0;
        test_reset();
        test_sequence();
        test_period15();
        test_pause_and_blocked_cfg();
        test_lockup();
        test_lockup_measure();
        test_saturate();
        test_zero_seed_with_meas();
        test_reset_mid_measure();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_prog.md
# lfsr_prog

Parametrised, runtime-programmable Fibonacci LFSR. It generalises the fixed 4-bit tap-select generator to any width, with:
- a full tap mask and seed loaded over a valid/ready handshake;
- automatic zero-state lock-up recovery;
- a built-in period-measurement engine for on-chip sequence characterisation.

It sits in the pattern/noise generation path and feeds pseudo-random words or a serial bit stream to downstream display and effect logic.

## Interface
- WIDTH, 8, LFSR width in bits (min 2)
- DEFAULT_TAPS, {WIDTH{1'b0}} with bits WIDTH-1 and 0 set, tap mask after reset
- DEFAULT_SEED, 1 in bit 0 only, seed after reset; must be nonzero
- CNT_W, 16, width of the period counter
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- en  in  1  advance LFSR one step per cycle when high
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration can be accepted
- cfg_taps  in  WIDTH  tap mask, bit i = lfsr[i] participates in feedback
- cfg_seed  in  WIDTH  new seed and recovery value
- meas_start  in  1  single-cycle request to measure period from current state
- lfsr  out  WIDTH  current state (registered)
- bit_out  out  1  lfsr[WIDTH-1]
- lockup  out  1  one-cycle pulse, zero-state recovery occurred
- period  out  CNT_W  last measured period
- period_valid  out  1  period holds a completed result

## Operation
- Step rule: fb = XOR-reduce(lfsr & taps); next = {lfsr[WIDTH-2:0], fb}.
- Internal registers: taps_r, seed_r, ref_r, cnt, FSM state {RUN, MEASURE}.
- Reset values: lfsr = DEFAULT_SEED, taps_r = DEFAULT_TAPS, seed_r = DEFAULT_SEED, lockup = 0, period = 0, period_valid = 0, state RUN.
- Config:
  - cfg_ready = (state == RUN).
  - A transfer occurs when cfg_valid & cfg_ready.
  - On a transfer: taps_r <= cfg_taps; seed_r <= (cfg_seed == 0 ? DEFAULT_SEED : cfg_seed); lfsr <= the same substituted seed; period_valid <= 0.
  - A transfer overrides en in that cycle.
- Lock-up recovery: if en and lfsr == 0 (no transfer this cycle), lfsr <= seed_r instead of a shift, and lockup = 1 in the following cycle.
- Priority per cycle: config transfer > lock-up recovery > normal step > hold.
- Measurement FSM:
  - RUN:
    - meas_start with no config transfer in the same cycle: ref_r <= lfsr, cnt <= 0, period_valid <= 0, go to MEASURE.
    - meas_start coinciding with a transfer is dropped.
  - MEASURE, on each en step (cnt_n = cnt+1):
    - If the next state equals ref_r: period <= cnt_n, period_valid <= 1, go to RUN.
    - Else if cnt_n is all ones: period <= all ones (saturated, no match), period_valid <= 1, go to RUN.
    - Else if a lock-up recovery occurs: period <= 0, period_valid <= 1, go to RUN.
    - Else cnt <= cnt_n.
  - MEASURE with en low: holds.
  - meas_start in MEASURE is ignored.
- period_valid stays high until the next accepted meas_start, a config transfer, or reset.

## Timing
- All outputs are registered. lfsr reflects a step one clock after the en cycle.
- bit_out is combinational from the lfsr register.
- Config latency is 1 cycle: lfsr shows the seed in the cycle after the transfer edge.
- lockup is a one-cycle pulse, high for the cycle after the recovery edge, never two cycles for one event.
- Period of N steps: period_valid rises in the cycle after the N-th en step.
- Reset asserted mid-MEASURE: immediate return to reset values, no partial result.

## Test plan
- WIDTH=4, cfg taps 4'b1001, seed 4'b1010, en held high -> lfsr sequence 1010, 0101, 1011, 0110, ...; meas_start -> period=15, period_valid=1 after 15 steps.
- WIDTH=4, taps 4'b0000, seed 4'b1010, en high -> 1010, 0100, 1000, 0000, 1010; lockup pulses exactly once, in the cycle lfsr returns to 1010.
- WIDTH=4, CNT_W=8, taps 4'b0011, seed 4'b1010, meas_start -> 1010 never recurs; period=8'hFF, period_valid=1 after 255 steps.
- cfg_valid with cfg_seed=0, DEFAULT_SEED=4'b0001 -> lfsr=0001, seed_r=0001. cfg_valid during MEASURE -> cfg_ready=0, no change. cfg_valid & meas_start together in RUN -> config taken, measurement not started.
- en toggled low during MEASURE with taps 4'b1001 -> count pauses, final period still 15. Lock-up during MEASURE -> period=0, period_valid=1.
- reset pulsed mid-MEASURE (async, between edges) -> lfsr=DEFAULT_SEED, period_valid=0, cfg_ready=1 immediately.
